// File: rtl/i2c_bit_phy.sv
// Bit-level I2C line engine: times one START/STOP/WRITE/READ op as four quarter-phases
// on open-drain SCL/SDA, samples SDA for read/ACK bits and waits out slave clock stretching.
module i2c_bit_phy #(
    parameter int QUARTER = 63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_valid,
    output logic       bit_ready,
    input  logic [1:0] bit_op,
    input  logic       bit_wdata,
    output logic       bit_done,
    output logic       bit_rdata,
    output logic       busy,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       scl_i,
    input  logic       sda_i
);
    localparam int CW = (QUARTER > 0) ? $clog2(QUARTER + 1) : 1;
    localparam logic [CW-1:0] TERM = CW'(QUARTER);

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic [2:0] {IDLE, Q0, Q1, Q2, Q3} state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [1:0]    op_reg;
    logic          wdata_reg;

    logic [1:0] pad_in;
    logic [1:0] pad_s;
    logic       scl_s;
    logic       sda_s;
    logic       stretch_hold;

    assign pad_in = {scl_i, sda_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= pad_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign pad_s[gi] = sync_reg;
        end
    endgenerate

    assign scl_s = pad_s[1];
    assign sda_s = pad_s[0];

    // A slave holding SCL low at the end of Q1 freezes the op until it lets go.
    assign stretch_hold = (state_reg == Q1) && (op_reg != OP_START) && !scl_s;

    assign bit_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);

    // {scl, sda} driven during quarter q of an op.
    function automatic logic [1:0] quarter_lines(input logic [1:0] op, input logic b,
                                                 input logic [1:0] q);
        logic [1:0] lines;
        lines = 2'b11;
        case (op)
            OP_START: lines = (q == 2'd3) ? 2'b00 : ((q == 2'd2) ? 2'b10 : 2'b11);
            OP_STOP:  lines = (q == 2'd0) ? 2'b00 : ((q == 2'd3) ? 2'b11 : 2'b10);
            OP_WRITE: lines = {(q == 2'd1) || (q == 2'd2), b};
            default:  lines = {(q == 2'd1) || (q == 2'd2), 1'b1};
        endcase
        return lines;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= OP_START;
            wdata_reg <= 1'b0;
            bit_done  <= 1'b0;
            bit_rdata <= 1'b0;
            scl_o     <= 1'b1;
            sda_o     <= 1'b1;
        end else begin
            bit_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bit_valid) begin
                        state_reg      <= Q0;
                        cnt_reg        <= '0;
                        op_reg         <= bit_op;
                        wdata_reg      <= bit_wdata;
                        {scl_o, sda_o} <= quarter_lines(bit_op, bit_wdata, 2'd0);
                    end
                end
                default: begin
                    if (cnt_reg != TERM) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end else if (!stretch_hold) begin
                        cnt_reg <= '0;
                        case (state_reg)
                            Q0: begin
                                state_reg      <= Q1;
                                {scl_o, sda_o} <= quarter_lines(op_reg, wdata_reg, 2'd1);
                            end
                            Q1: begin
                                state_reg      <= Q2;
                                {scl_o, sda_o} <= quarter_lines(op_reg, wdata_reg, 2'd2);
                            end
                            Q2: begin
                                state_reg      <= Q3;
                                {scl_o, sda_o} <= quarter_lines(op_reg, wdata_reg, 2'd3);
                                if (op_reg == OP_READ) begin
                                    bit_rdata <= sda_s;
                                end
                            end
                            default: begin
                                state_reg <= IDLE;
                                bit_done  <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule
